// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared owner and arbitration state types for the RAM port arbiters
package mem_arb_pkg;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick with lock override, one-hot grant
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic       i_a_req,
    input  logic       i_b_req,
    input  owner_t     i_prio,
    input  arb_state_t i_st,
    output logic [1:0] o_gnt
);

    // bit 0 grants A, bit 1 grants B; a lock hands the port to its owner only
    always_comb begin
        o_gnt = 2'b00;
        case (i_st)
            LOCK_A: o_gnt[0] = i_a_req;
            LOCK_B: o_gnt[1] = i_b_req;
            default: begin
                if (i_a_req && (!i_b_req || i_prio == OWN_A)) begin
                    o_gnt = 2'b01;
                end else if (i_b_req) begin
                    o_gnt = 2'b10;
                end
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares RAM port 1 between CPU LSU and debug loader
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int W = 32,
    parameter int L = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_req,
    input  logic                 a_wr,
    input  logic                 a_lock,
    input  logic [$clog2(L)-1:0] a_addr,
    input  logic [W-1:0]         a_wdata,
    input  logic                 b_req,
    input  logic                 b_wr,
    input  logic                 b_lock,
    input  logic [$clog2(L)-1:0] b_addr,
    input  logic [W-1:0]         b_wdata,
    output logic                 a_gnt,
    output logic                 b_gnt,
    output logic                 a_rvalid,
    output logic                 b_rvalid,
    output logic [W-1:0]         a_rdata,
    output logic [W-1:0]         b_rdata,
    output logic                 ram_wr_ena,
    output logic [$clog2(L)-1:0] ram_addr,
    output logic [W-1:0]         ram_wr_data,
    input  logic [W-1:0]         ram_rd_data
);

    arb_state_t r_st;
    owner_t     r_prio;
    owner_t     r_rd_owner;
    logic       r_rd_pend;
    logic [1:0] w_pick;
    logic       w_a_rd;
    logic       w_b_rd;

    // Requests are masked while reset is held so no access reaches the RAM
    rr_pick2 u_pick (
        .i_a_req (a_req & ~rst),
        .i_b_req (b_req & ~rst),
        .i_prio  (r_prio),
        .i_st    (r_st),
        .o_gnt   (w_pick)
    );

    assign a_gnt  = w_pick[0];
    assign b_gnt  = w_pick[1];
    assign w_a_rd = a_gnt & ~a_wr;
    assign w_b_rd = b_gnt & ~b_wr;

    // Winner's fields drive the RAM port; idle port presents all zeros
    always_comb begin
        ram_wr_ena  = 1'b0;
        ram_addr    = '0;
        ram_wr_data = '0;
        if (a_gnt) begin
            ram_wr_ena  = a_wr;
            ram_addr    = a_addr;
            ram_wr_data = a_wdata;
        end else if (b_gnt) begin
            ram_wr_ena  = b_wr;
            ram_addr    = b_addr;
            ram_wr_data = b_wdata;
        end
    end

    // Round-robin pointer and lock FSM; pointer frozen while locked, handed over on unlock
    always_ff @(posedge clk) begin
        if (rst) begin
            r_st   <= ARB;
            r_prio <= OWN_A;
        end else begin
            case (r_st)
                ARB: begin
                    if (a_gnt) begin
                        r_prio <= OWN_B;
                        if (a_lock) r_st <= LOCK_A;
                    end else if (b_gnt) begin
                        r_prio <= OWN_A;
                        if (b_lock) r_st <= LOCK_B;
                    end
                end
                LOCK_A: begin
                    if (a_gnt && !a_lock) begin
                        r_st   <= ARB;
                        r_prio <= OWN_B;
                    end
                end
                LOCK_B: begin
                    if (b_gnt && !b_lock) begin
                        r_st   <= ARB;
                        r_prio <= OWN_A;
                    end
                end
                default: r_st <= ARB;
            endcase
        end
    end

    // Read tag: remembers who owns the RAM data arriving next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= OWN_A;
        end else begin
            r_rd_pend  <= w_a_rd | w_b_rd;
            r_rd_owner <= b_gnt ? OWN_B : OWN_A;
        end
    end

    // A response whose cycle coincides with reset is dropped rather than delivered
    always_comb begin
        a_rvalid = r_rd_pend & (r_rd_owner == OWN_A) & ~rst;
        b_rvalid = r_rd_pend & (r_rd_owner == OWN_B) & ~rst;
        a_rdata  = a_rvalid ? ram_rd_data : '0;
        b_rdata  = b_rvalid ? ram_rd_data : '0;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single port of the synchronous-read dual-port RAM between two requesters: requester A (CPU load/store unit) and requester B (debug/program loader). Requests are granted by round-robin, with an optional lock for atomic read-modify-write sequences. Read data is routed back to the owning requester one cycle after grant. The block sits between the requesters and RAM port 1; port 0 remains dedicated to instruction fetch.

## Interface
Parameters:
- W, 32, data width; matches the RAM word width.
- L, 128, RAM depth in words; the address width is $clog2(L).

Ports (AW = $clog2(L)):
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- a_req / b_req  in  1  request valid; must be held with stable fields until the matching gnt.
- a_wr / b_wr  in  1  1 = write, 0 = read.
- a_lock / b_lock  in  1  keep ownership after this grant (atomic sequence).
- a_addr / b_addr  in  AW  word address.
- a_wdata / b_wdata  in  W  write data.
- a_gnt / b_gnt  out  1  request accepted this cycle; combinational from req and state.
- a_rvalid / b_rvalid  out  1  read data valid, registered.
- a_rdata / b_rdata  out  W  read data; equals ram_rd_data while rvalid is high, else 0.
- ram_wr_ena  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_wr_data  out  W  RAM write data.
- ram_rd_data  in  W  RAM read data; valid one cycle after the address is presented.

## Operation
- At most one grant per cycle; a_gnt and b_gnt are never both high.
- The granted requester's addr, wdata and wr drive the RAM port in the same cycle.
  - ram_wr_ena = gnt & wr.
  - With no grant: ram_wr_ena = 0, ram_addr = 0, ram_wr_data = 0.
- Round-robin rule:
  - A 1-bit pointer `prio` names the favoured requester.
  - If both request, the favoured one wins.
  - After any grant, `prio` flips to the other requester.
- State machine `st` has three states: ARB, LOCK_A, LOCK_B.
  - ARB: normal round-robin. A grant with the winner's lock = 1 moves to LOCK_A or LOCK_B.
  - LOCK_A: only A can be granted; b_req is ignored. An A grant with a_lock = 0 returns to ARB. `prio` is not updated while locked; on exit it is set to B.
  - LOCK_B: symmetric to LOCK_A.
  - There is no lock timeout. A locked owner that stops requesting holds the port indefinitely; this is a software contract.
- Read tracking:
  - A read grant registers `rd_owner` and `rd_pend` = 1.
  - In the next cycle, owner rvalid = 1 and rdata = ram_rd_data.
  - Back-to-back reads (one per cycle, either requester) are fully pipelined.
- Writes produce no response; gnt is the acknowledgement.
- Read after write to the same address in consecutive grants returns the new data. The write commits at the grant-cycle edge, and the read samples after it.

## Timing
- Reset values:
  - st = ARB, prio = A, rd_pend = 0.
  - All gnt and rvalid outputs = 0; rdata = 0; ram_wr_ena = 0.
- Read latency: grant in cycle N gives rvalid in cycle N+1, for exactly one cycle.
- Throughput: one access per cycle. A request to an idle port is granted in the same cycle it is asserted.
- Simultaneous requests:
  - Loser waits exactly one cycle if the winner does not request again.
  - Under continuous contention without lock, grants strictly alternate A, B, A, B...
- Reset during an in-flight read: rvalid stays 0 in the following cycle, and that response is dropped. Reset also clears any lock.
- req deasserted without gnt: legal; nothing is issued.

## Structure
- Shared package `mem_arb_pkg` holds:
  - `owner_t` enum: OWN_A, OWN_B.
  - `arb_state_t` enum: ARB, LOCK_A, LOCK_B.
  - Reused by the future 3-requester variant.
- One sub-module is natural: `rr_pick2`. It is purely combinational: inputs are the two reqs, prio and the lock state; the output is the one-hot grant.
- Everything else (pointer, FSM, read tag register, RAM muxing) lives in mem_port_arbiter. Target size is about 150–250 lines.

## Test plan
- Reset, then idle for 5 cycles -> all gnt/rvalid 0, ram_wr_ena 0, ram_addr 0.
- A writes 0xDEADBEEF to address 5, then reads address 5 on the next cycle -> a_gnt both cycles; a_rvalid 1 cycle later with a_rdata = 0xDEADBEEF; b_rvalid never asserts.
- A and B continuously read addresses 1 and 2 (preloaded 0x11 and 0x22) for 6 cycles -> grants A, B, A, B, A, B. Responses arrive one cycle later to the matching owner with the correct data.
- A issues a read of address 3 with a_lock = 1, then a write of 0x33 with a_lock = 0, while b_req is held high throughout -> B is blocked during LOCK_A and granted in the cycle after A's unlocking write. B's subsequent read of address 3 returns 0x33.
- B read granted, then rst asserted in the next cycle -> b_rvalid stays 0, and st, prio and gnt are back at reset values.
- B alone requests 4 writes back-to-back -> b_gnt high 4 consecutive cycles, and RAM contents match the written data.
